seg7_mux_driver: RTL
====================

Name: seg7_mux_driver

Overview:
Parametrised, time-multiplexed driver for an N-digit common-anode 7-segment display. It takes a packed word of hex nibbles, per-digit dot and blank masks, and a load strobe. Loaded values are double-buffered and committed only at frame boundaries, so the display never tears. The block sits between the game score/status logic and the board display pins, replacing per-digit combinational decoding plus an external scan counter.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8).
REFRESH_DIV, 100000, CLK cycles each digit stays selected (>=2); 100 MHz gives 1 kHz per digit.
ACTIVE_LOW, 1, 1 means segment, dot and select outputs are active-low; 0 inverts all three.

Ports:
CLK  input  1  system clock
RESET  input  1  synchronous, active-high reset
DIGITS_IN  input  4*NUM_DIGITS  hex nibbles; digit k = bits [4k+3:4k], digit 0 rightmost
DOTS_IN  input  NUM_DIGITS  1 = dot lit on digit k
BLANK_IN  input  NUM_DIGITS  1 = digit k dark (segments and dot off)
LOAD_IN  input  1  one-cycle strobe; captures DIGITS_IN/DOTS_IN/BLANK_IN into the pending buffer
SEG_SELECT_OUT  output  NUM_DIGITS  one-hot digit enable (active-low when ACTIVE_LOW=1)
HEX_OUT  output  8  [6:0] segments g..a, [7] dot
FRAME_TICK_OUT  output  1  one-cycle pulse at each frame commit

Behaviour:
- Interface: one clock CLK; RESET synchronous, active-high. Nothing is sampled asynchronously.
- Reset: prescaler cnt=0, digit index idx=0, pending_valid=0, pending and active digits/dots=0, active blank mask all ones, FRAME_TICK_OUT=0. SEG_SELECT_OUT is all off (4'b1111 for defaults). HEX_OUT is all off (8'hFF for ACTIVE_LOW=1).
- Prescaler: cnt counts 0..REFRESH_DIV-1 and wraps. tick = (cnt==REFRESH_DIV-1).
- On tick, idx advances. It wraps from NUM_DIGITS-1 to 0.
- commit = tick && idx==NUM_DIGITS-1.
- LOAD_IN: on a load cycle, pending <= inputs and pending_valid <= 1. A later LOAD before commit overwrites pending (last load wins).
- Commit when pending_valid=1: active <= pending and pending_valid <= 0.
- LOAD_IN in the commit cycle: the commit uses the inputs presented that cycle (bypass), and pending_valid ends at 0.
- Commit with pending_valid=0 leaves active unchanged.
- FRAME_TICK_OUT = 1 for exactly the cycle after each commit edge, whether or not data changed.
- Output registers update every cycle from idx (pre-edge value) and the active buffer, so outputs lag idx by one cycle.
- SEG_SELECT_OUT asserts only bit idx. With the defaults: idx0=1110, idx1=1101, idx2=1011, idx3=0111.
- Decoding uses the standard hex font, 0-F, including A b C d E F. With ACTIVE_LOW=1: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=98, A=88, b=83, C=C6, d=A1, E=86, F=8E (these include dot off).
- Dot lit means HEX_OUT[7] is 0 when ACTIVE_LOW=1.
- A blanked digit is still selected in its slot (constant scan duty) with HEX_OUT all off.
- Mid-operation RESET: all state returns to reset values on the next edge. The pending load is discarded.

Optional Feature:
Macro SEG7_LZS_EN enables leading-zero suppression.
- Defined: at commit, each digit k>0 is additionally blanked if it and all higher digits are 0. Digit 0 is never suppressed by this rule. Explicit BLANK_IN bits still apply.
- Undefined: digits display exactly as loaded, zeros included.

Test Plan:
(Defaults except REFRESH_DIV=4, ACTIVE_LOW=1.)
- Hold RESET 3 cycles, then release with no load. During reset: SEG_SELECT_OUT=1111, HEX_OUT=FF. After release, select walks 1110, 1101, 1011, 0111 every 4 cycles; HEX_OUT stays FF; FRAME_TICK_OUT pulses every 16 cycles.
- LOAD DIGITS_IN=0x1234, DOTS_IN=0001, BLANK_IN=0000 mid-frame. The current frame stays FF. From the next frame: digit0 HEX_OUT=19 (4 with dot), digit1=B0, digit2=A4, digit3=F9.
- Two loads in one frame, 0x1111 then 0x2222. Only 2222 appears (A4 on all digits) after the commit.
- LOAD 0x9999 asserted exactly on the commit cycle. The next frame already shows 98 on all digits; no stale frame appears.
- Assert RESET during digit2 of a loaded display, with a pending load outstanding. Outputs go to 1111/FF on the next edge. After release, display stays blank and the pending load never commits.
- With SEG7_LZS_EN, load 0x0050: digits 3 and 2 show FF, digit1=92, digit0=C0. Load 0x0000: only digit0 shows C0. Without the macro, 0x0050 shows C0, C0, 92, C0.

Source files
------------

// File: rtl/seg7_mux_driver.sv
// Time-multiplexed N-digit 7-segment driver with frame-synchronous double buffering.
// Optional macro SEG7_LZS_EN adds leading-zero suppression at commit time.
module seg7_mux_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [4*NUM_DIGITS-1:0] DIGITS_IN,
  input  logic [NUM_DIGITS-1:0]   DOTS_IN,
  input  logic [NUM_DIGITS-1:0]   BLANK_IN,
  input  logic                    LOAD_IN,
  output logic [NUM_DIGITS-1:0]   SEG_SELECT_OUT,
  output logic [7:0]              HEX_OUT,
  output logic                    FRAME_TICK_OUT
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH_DIV - 1);
  localparam logic POL_LOW = (ACTIVE_LOW != 0);

  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_pend_valid;
  logic [4*NUM_DIGITS-1:0] r_pend_digits;
  logic [NUM_DIGITS-1:0]   r_pend_dots;
  logic [NUM_DIGITS-1:0]   r_pend_blank;
  logic [4*NUM_DIGITS-1:0] r_act_digits;
  logic [NUM_DIGITS-1:0]   r_act_dots;
  logic [NUM_DIGITS-1:0]   r_act_blank;
  logic                    r_frame_tick;
  logic [NUM_DIGITS-1:0]   r_sel;
  logic [7:0]              r_hex;

  logic                    w_tick;
  logic                    w_commit;
  logic [4*NUM_DIGITS-1:0] w_new_digits;
  logic [NUM_DIGITS-1:0]   w_new_dots;
  logic [NUM_DIGITS-1:0]   w_new_blank;
  logic [3:0]              w_cur_digit;
  logic                    w_cur_dot;
  logic                    w_cur_blank;
  logic [NUM_DIGITS-1:0]   w_sel_ah;
  logic [7:0]              w_hex_ah;

  // Active-high segments, bit order g..a.
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'h0: seg_decode = 7'h3F;  4'h1: seg_decode = 7'h06;
      4'h2: seg_decode = 7'h5B;  4'h3: seg_decode = 7'h4F;
      4'h4: seg_decode = 7'h66;  4'h5: seg_decode = 7'h6D;
      4'h6: seg_decode = 7'h7D;  4'h7: seg_decode = 7'h07;
      4'h8: seg_decode = 7'h7F;  4'h9: seg_decode = 7'h67;
      4'hA: seg_decode = 7'h77;  4'hB: seg_decode = 7'h7C;
      4'hC: seg_decode = 7'h39;  4'hD: seg_decode = 7'h5E;
      4'hE: seg_decode = 7'h79;  default: seg_decode = 7'h71;
    endcase
  endfunction

  assign w_tick   = (r_cnt == LAST_CNT);
  assign w_commit = w_tick && (r_idx == LAST_IDX);

  // LOAD_IN is a one-cycle strobe with no back-pressure; a load landing on the
  // commit cycle bypasses the pending buffer straight into the active buffer.
  always_comb begin
    w_new_digits = LOAD_IN ? DIGITS_IN : r_pend_digits;
    w_new_dots   = LOAD_IN ? DOTS_IN   : r_pend_dots;
    w_new_blank  = LOAD_IN ? BLANK_IN  : r_pend_blank;
`ifdef SEG7_LZS_EN
    begin
      logic w_zero_above;
      w_zero_above = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
        w_zero_above = w_zero_above && (w_new_digits[4*k +: 4] == 4'h0);
        if (w_zero_above) w_new_blank[k] = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    w_cur_digit = 4'h0;
    w_cur_dot   = 1'b0;
    w_cur_blank = 1'b1;
    w_sel_ah    = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_cur_digit = r_act_digits[4*k +: 4];
        w_cur_dot   = r_act_dots[k];
        w_cur_blank = r_act_blank[k];
        w_sel_ah[k] = 1'b1;
      end
    end
    w_hex_ah = w_cur_blank ? 8'h00 : {w_cur_dot, seg_decode(w_cur_digit)};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_cnt         <= '0;
      r_idx         <= '0;
      r_pend_valid  <= 1'b0;
      r_pend_digits <= '0;
      r_pend_dots   <= '0;
      r_pend_blank  <= '1;
      r_act_digits  <= '0;
      r_act_dots    <= '0;
      r_act_blank   <= '1;
      r_frame_tick  <= 1'b0;
      r_sel         <= POL_LOW ? '1 : '0;
      r_hex         <= POL_LOW ? 8'hFF : 8'h00;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick) r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
      if (w_commit) begin
        if (LOAD_IN || r_pend_valid) begin
          r_act_digits <= w_new_digits;
          r_act_dots   <= w_new_dots;
          r_act_blank  <= w_new_blank;
        end
        r_pend_valid <= 1'b0;
      end else if (LOAD_IN) begin
        r_pend_digits <= DIGITS_IN;
        r_pend_dots   <= DOTS_IN;
        r_pend_blank  <= BLANK_IN;
        r_pend_valid  <= 1'b1;
      end
      r_frame_tick <= w_commit;
      r_sel        <= POL_LOW ? ~w_sel_ah : w_sel_ah;
      r_hex        <= POL_LOW ? ~w_hex_ah : w_hex_ah;
    end
  end

  assign SEG_SELECT_OUT = r_sel;
  assign HEX_OUT        = r_hex;
  assign FRAME_TICK_OUT = r_frame_tick;

endmodule
